// File: rtl/alu_cond_pkg.sv
// alu_cond_pkg: condition codes, flag bit positions {V,Z,S,C}, queue state enum, condition evaluator
package alu_cond_pkg;
  localparam logic [3:0] CC_EQ = 4'd0, CC_NE = 4'd1, CC_CS = 4'd2, CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4, CC_PL = 4'd5, CC_VS = 4'd6, CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8, CC_LS = 4'd9, CC_GE = 4'd10, CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15;
  localparam int FV = 3, FZ = 2, FS = 1, FC = 0;
  localparam int FIFO_W = 40;
  typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    logic [7:0] base;
    base = {1'b1, !f[FZ] & (f[FS] == f[FV]), f[FS] == f[FV], f[FC] & !f[FZ], f[FV], f[FS], f[FC], f[FZ]};
    return base[cc[3:1]] ^ cc[0];
  endfunction
endpackage

// File: rtl/alu_cond_fifo.sv
// alu_cond_fifo: DEPTH-entry queue; push on in_valid&in_ready, pop on out_valid&out_ready, out_data=0 when empty, level/state tracked
module alu_cond_fifo
  import alu_cond_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W = FIFO_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  state_t state, state_d;
  logic push, pop;
  assign in_ready = state != ST_FULL;
  assign out_valid = state != ST_EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_data = out_valid ? mem[rp] : '0;
  always_comb begin
    state_d = state == ST_EMPTY ? (push ? ST_PARTIAL : ST_EMPTY) :
              state == ST_FULL ? (pop ? ST_PARTIAL : ST_FULL) :
              (push & !pop & level == LAST) ? ST_FULL :
              (pop & !push & level == ONE) ? ST_EMPTY : ST_PARTIAL;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      state <= state_d;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= in_data;
endmodule

// File: rtl/alu_cond_unit.sv
// alu_cond_unit: queued ALU results with per-entry condition evaluation; head {result,flags,taken} out, last popped flags held
module alu_cond_unit
  import alu_cond_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_result,
  input  logic [3:0]             in_flags,
  input  logic [3:0]             in_cond,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [3:0]             out_flags,
  output logic                   out_taken,
  output logic [3:0]             last_flags,
  output logic [$clog2(DEPTH):0] level
);
  logic [FIFO_W-1:0] head;
  alu_cond_fifo #(.DEPTH(DEPTH), .W(FIFO_W)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data({in_result, in_flags, in_cond}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(head),
    .level(level)
  );
  assign out_result = head[39:8];
  assign out_flags = head[7:4];
  assign out_taken = out_valid & cond_eval(head[3:0], head[7:4]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_flags <= '0;
    else if (out_valid & out_ready) last_flags <= out_flags;
  end
endmodule

// File: tb/tb_alu_cond_unit.sv
// tb_alu_cond_unit: directed self-checking bench for alu_cond_unit
module tb_alu_cond_unit;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, out_taken;
  logic [31:0] in_result = '0, out_result;
  logic [3:0] in_flags = '0, in_cond = '0, out_flags, last_flags;
  logic [$clog2(DEPTH):0] level;
  int n_chk = 0, n_pass = 0;
  alu_cond_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_taken(out_taken), .last_flags(last_flags), .level(level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] r, input logic [3:0] f, input logic [3:0] c);
    in_valid = 1; in_result = r; in_flags = f; in_cond = c;
    step();
    in_valid = 0;
  endtask
  task automatic pop();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask
  function automatic logic model(input logic [3:0] cc, input logic [3:0] f);
    logic v, z, s, c;
    {v, z, s, c} = f;
    case (cc)
      0: return z;           1: return !z;
      2: return c;           3: return !c;
      4: return s;           5: return !s;
      6: return v;           7: return !v;
      8: return c & !z;      9: return !c | z;
      10: return s == v;     11: return s != v;
      12: return !z & (s == v); 13: return z | (s != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  initial begin
    logic [31:0] q[$];
    int sent, recv, cyc;
    logic p_push, p_pop;
    #3;
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst level", level, 0);
    chk("rst last_flags", last_flags, 0);
    #19 rst_n = 1;
    push(32'h0, 4'b0100, 4'd0);
    chk("eq out_valid", out_valid, 1);
    chk("eq taken", out_taken, 1);
    chk("eq level", level, 1);
    pop();
    chk("eq last_flags", last_flags, 4'b0100);
    chk("eq level0", level, 0);
    chk("empty result", out_result, 0);
    chk("empty taken", out_taken, 0);
    push(32'h11, 4'b1000, 4'd11);
    push(32'h22, 4'b1000, 4'd10);
    chk("lt result", out_result, 32'h11);
    chk("lt taken", out_taken, 1);
    pop();
    chk("ge result", out_result, 32'h22);
    chk("ge taken", out_taken, 0);
    pop();
    for (int i = 0; i < DEPTH; i++) push(32'h100 + i, 4'h1, 4'd14);
    chk("full in_ready", in_ready, 0);
    chk("full level", level, DEPTH);
    push(32'hdead, 4'h0, 4'd0);
    chk("refused level", level, DEPTH);
    in_valid = 1; in_result = 32'hbeef; out_ready = 1;
    step();
    in_valid = 0; out_ready = 0;
    chk("full pp level", level, DEPTH - 1);
    for (int i = 1; i < DEPTH; i++) begin
      chk("full drain", out_result, 32'h100 + i);
      pop();
    end
    chk("drained valid", out_valid, 0);
    sent = 0; recv = 0; cyc = 0;
    while (recv < 3 * DEPTH && cyc < 500) begin
      in_valid = sent < 3 * DEPTH;
      in_result = 32'ha000 + sent;
      in_flags = 4'(sent); in_cond = 4'd14;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      p_push = in_valid & in_ready;
      p_pop = out_valid & out_ready;
      if (p_pop) begin
        chk("stream order", out_result, q.size() ? q.pop_front() : 32'hffffffff);
        recv++;
      end
      if (p_push) begin
        q.push_back(in_result);
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 0; out_ready = 0;
    chk("stream done", recv, 3 * DEPTH);
    chk("stream level", level, 0);
    for (int i = 0; i < 4; i++) push(32'h300 + i, 4'hf, 4'd0);
    pop();
    chk("pre-rst level", level, 3);
    chk("pre-rst last", last_flags, 4'hf);
    #1 rst_n = 0;
    #1;
    chk("async valid", out_valid, 0);
    chk("async level", level, 0);
    chk("async last", last_flags, 0);
    @(negedge clk) rst_n = 1;
    step();
    for (int cc = 0; cc < 16; cc++)
      for (int f = 0; f < 16; f++) begin
        push(32'(f), 4'(f), 4'(cc));
        chk($sformatf("cond %0d flags %0h", cc, f), out_taken, model(4'(cc), 4'(f)));
        pop();
      end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
